// File: rtl/div_pkg.sv
// Shared state type, default width and sign helper for the iterative divider.
// abs_val exists only when SIGNED_DIV_EN is defined.
package div_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int MAX_W     = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

`ifdef SIGNED_DIV_EN
  // Callers zero-extend a WIDTH-bit value and keep the low WIDTH bits (WIDTH <= MAX_W).
  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction
`endif

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {P,Q} left, trial-subtract the divisor, restore on borrow.
// Purely combinational, no handshake.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   i_p,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_p,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH+1:0] w_shift_p;
  logic [WIDTH+1:0] w_trial;
  logic             w_borrow;

  // P stays below the divisor, so the extra top bit of the trial is a clean borrow-out.
  assign w_shift_p = {i_p, i_q[WIDTH-1]};
  assign w_trial   = w_shift_p - {2'b00, i_divisor};
  assign w_borrow  = w_trial[WIDTH+1];

  assign o_p = w_borrow ? w_shift_p[WIDTH:0] : w_trial[WIDTH:0];
  assign o_q = {i_q[WIDTH-2:0], ~w_borrow};

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider: done at accept+WIDTH+1 (accept+1 on divide-by-zero); start ignored while busy.
// Define SIGNED_DIV_EN for two's-complement operands (truncating toward zero).
module seq_divider
  import div_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_p;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;
  logic             r_dz_pend;

  logic             w_accept;
  logic             w_dz_in;
  logic [WIDTH:0]   w_p_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  assign w_dz_in = (divisor == '0);

`ifdef SIGNED_DIV_EN
  logic             r_neg_q;
  logic             r_neg_r;
  logic [MAX_W-1:0] w_dvd_abs;
  logic [MAX_W-1:0] w_dvs_abs;

  assign w_dvd_abs = abs_val(MAX_W'(dividend), dividend[WIDTH-1]);
  assign w_dvs_abs = abs_val(MAX_W'(divisor), divisor[WIDTH-1]);
  assign w_dvd_mag = w_dvd_abs[WIDTH-1:0];
  assign w_dvs_mag = w_dvs_abs[WIDTH-1:0];
`else
  assign w_dvd_mag = dividend;
  assign w_dvs_mag = divisor;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_p      (r_p),
    .i_q      (r_q),
    .i_divisor(r_divisor),
    .o_p      (w_p_nxt),
    .o_q      (w_q_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = w_dz_in ? DONE : RUN;
        end
      end
      RUN:     if (r_cnt == CNT_W'(1)) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // On divide-by-zero r_q carries the raw dividend straight through to the remainder.
  always_comb begin
    w_quot = r_q;
    w_rem  = r_p[WIDTH-1:0];
    if (r_dz_pend) begin
      w_quot = '1;
      w_rem  = r_q;
    end
`ifdef SIGNED_DIV_EN
    else begin
      if (r_neg_q) w_quot = ~r_q + 1'b1;
      if (r_neg_r) w_rem  = ~r_p[WIDTH-1:0] + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_p         <= '0;
      r_q         <= '0;
      r_divisor   <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dz        <= 1'b0;
      r_dz_pend   <= 1'b0;
`ifdef SIGNED_DIV_EN
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_busy    <= 1'b1;
        r_dz      <= 1'b0;
        r_dz_pend <= w_dz_in;
        r_p       <= '0;
        r_cnt     <= CNT_W'(WIDTH);
        r_divisor <= w_dvs_mag;
        r_q       <= w_dz_in ? dividend : w_dvd_mag;
`ifdef SIGNED_DIV_EN
        r_neg_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        r_neg_r   <= dividend[WIDTH-1];
`endif
      end else if (r_state == RUN) begin
        r_p   <= w_p_nxt;
        r_q   <= w_q_nxt;
        r_cnt <= r_cnt - 1'b1;
      end else if (r_state == DONE) begin
        r_busy      <= 1'b0;
        r_done      <= 1'b1;
        r_dz        <= r_dz_pend;
        r_quotient  <= w_quot;
        r_remainder <= w_rem;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dz;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed bench for seq_divider with a queue scoreboard and an arithmetic reference model.
`timescale 1ns/1ps
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int due);
    exp_t e;
    e.due = due;
    e.dz  = 1'b0;
    if (b == 0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end
`ifdef SIGNED_DIV_EN
    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = a;
      e.r = '0;
    end else begin
      e.q = $signed(a) / $signed(b);
      e.r = $signed(a) % $signed(b);
    end
`else
    else begin
      e.q = a / b;
      e.r = a % b;
    end
`endif
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done q=%0h r=%0h cycle=%0d", quotient, remainder, cyc);
      end else begin
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", div_by_zero, e.dz);
        check("done_cycle", cyc, e.due);
      end
    end
  end

  // Called at a negedge; start is sampled at the next posedge (the accept edge).
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(model(a, b, cyc + 1 + ((b == 0) ? 1 : W + 1)));
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic wait_done(input int limit);
    logic [W-1:0] q0;
    int n;
    bit held;
    q0   = quotient;
    n    = 0;
    held = 1'b1;
    while (done !== 1'b1 && n < limit) begin
      if (quotient !== q0) held = 1'b0;
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL done_timeout waited=%0d cycles", n);
    end
    check("quotient_held_while_busy", held, 1);
    check("busy_low_at_done", busy, 0);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    launch(a, b);
    wait_done(W + 10);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_div_by_zero", div_by_zero, 0);
    rst = 1'b0;

    op(100, 7);
    op(32'hFFFF_FFFF, 1);
    op(5, 32'hFFFF_FFFF);
    op(0, 9);
    op(5, 0);
    op(6, 3);
    op(32'hFFFF_FFF9, 2);
    op(7, 32'hFFFF_FFFE);
    op(32'h8000_0000, 32'hFFFF_FFFF);

    // Start pulsed mid-operation must be dropped; then a back-to-back op.
    @(negedge clk);
    launch(100, 7);
    repeat (9) @(negedge clk);
    start    = 1'b1;
    dividend = 50;
    divisor  = 5;
    @(negedge clk);
    start = 1'b0;
    check("busy_ignores_start", busy, 1);
    wait_done(W + 10);
    op(6, 3);
    repeat (W + 5) @(negedge clk);

    // Reset in flight discards the operation.
    @(negedge clk);
    launch(100, 7);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    repeat (W + 8) @(negedge clk);
    op(9, 4);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = $urandom_range(1, 15);
        2:       b = a >> $urandom_range(0, 31);
        default: b = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255);
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
      op(a, b);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Iterative radix-2 restoring integer divider, the inverse operation to the team's combinational adder and multiplier datapaths. It accepts one dividend/divisor pair on a start pulse and resolves one quotient bit per clock using an internal trial subtractor. It returns quotient and remainder with a done pulse. It sits beside the multiplier units in the arithmetic block and shares their operand width.

Parameters:
WIDTH, 32, operand, quotient and remainder width in bits (WIDTH >= 2)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  numerator; captured on accepted start
divisor  input  WIDTH  denominator; captured on accepted start
busy  output  1  high from the cycle after acceptance until done
done  output  1  one-cycle pulse; results valid in the same cycle
quotient  output  WIDTH  registered result
remainder  output  WIDTH  registered result
div_by_zero  output  1  registered flag; valid with done, held until next acceptance

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy, done, div_by_zero=0; quotient, remainder=0; counter=0. Reset wins over any other event, including mid-operation, and discards the operation in flight.
- FSM has three states:
  - IDLE: start=1 is accepted at edge E0; operands are latched and busy=1 from E0.
    - If divisor=0: next state is DONE.
    - Otherwise: next state is RUN; partial remainder P=0 (WIDTH+1 bits); Q=dividend; counter=WIDTH.
  - RUN, each cycle: shift {P,Q} left by 1; trial T=P-divisor at WIDTH+1 bits.
    - If T is non-negative: P=T and Q[0]=1.
    - Otherwise: P is kept and Q[0]=0.
    - counter decrements; when it reaches 0, next state is DONE.
  - DONE, one cycle: quotient=Q; remainder=P[WIDTH-1:0]; done=1; busy=0. Next state is IDLE.
- Latency: done asserts at edge E0+WIDTH+1 (33 cycles for WIDTH=32). Divide-by-zero asserts done at E0+1.
- Divide-by-zero: quotient=all ones; remainder=dividend; div_by_zero=1.
- start while busy (RUN or DONE) is ignored and not queued. start may be asserted in the cycle after done and is accepted.
- Outputs hold their last values in IDLE until the next operation completes. quotient and remainder do not change during RUN.
- Operand inputs need to be stable only at the accepting edge.
- Overflow is impossible in unsigned mode: quotient <= dividend, remainder < divisor.

Optional Feature:
SIGNED_DIV_EN
- Defined: operands are two's complement.
  - Magnitudes are taken at acceptance and the unsigned core runs unchanged.
  - At DONE the quotient is negated if operand signs differ. The remainder takes the dividend's sign (truncation toward zero).
  - Latency is unchanged; negation happens in the DONE result register.
  - MIN/-1 gives quotient=MIN, remainder=0, div_by_zero=0.
  - Divide-by-zero gives quotient=-1 and remainder=dividend.
- Undefined: purely unsigned; no sign logic is synthesized.

Decomposition:
- Package div_pkg holds:
  - state typedef (IDLE, RUN, DONE);
  - default width localparam;
  - helper function for two's-complement absolute value, used only under SIGNED_DIV_EN.
- One natural sub-module is div_step: a combinational single restoring iteration.
  - Inputs: P, Q, divisor.
  - Outputs: next P, next Q.
  - Internally a WIDTH+1-bit subtract; the borrow-out selects restore.
- seq_divider holds the FSM, counter and registers, and instantiates one div_step.

Test Plan:
- Basic: start with 100/7 at E0 -> busy=1 from E0; done=1 exactly at E0+33 with quotient=14, remainder=2, div_by_zero=0.
- Extremes: 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0; 5/0xFFFFFFFF -> q=0, r=5; 0/9 -> q=0, r=0.
- Divide by zero: 5/0 -> done at E0+1 with q=0xFFFFFFFF, r=5, div_by_zero=1. A following 6/3 clears the flag and gives q=2, r=0.
- Start while busy: 100/7 accepted, then 50/5 pulsed at E0+10 -> only q=14, r=2 completes; no second done. Back-to-back start the cycle after done is accepted.
- Reset mid-op: rst at E0+12 -> next cycle IDLE, busy=0, quotient=0, no done. A new 9/4 afterwards gives q=2, r=1.
- SIGNED_DIV_EN: -7/2 -> q=-3, r=-1; 7/-2 -> q=-3, r=1; 0x80000000/-1 -> q=0x80000000, r=0.
